multi_axis_servo_driver: RTL and testbench

// - N-channel servo PWM driver; successor to the fixed 3-servo PWM path of the robotic arm top level.
// - Selects per-frame coordinates from memory or accelerometer, maps signed coords to pulse widths,

---
 rtl/multi_axis_servo_driver_pkg.sv | 26 ++
 rtl/multi_axis_servo_driver_servo_channel.sv | 72 +++++++
 rtl/multi_axis_servo_driver.sv | 82 ++++++++
 tb/tb_multi_axis_servo_driver.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/multi_axis_servo_driver_pkg.sv
// Shared helpers for the servo driver: coordinate-to-pulse mapping and frame geometry.
package multi_axis_servo_driver_pkg;

    localparam int COORD_EXT_W = 32;

    function automatic int period_clocks(input int clk_freq, input int pwm_freq);
        return clk_freq / pwm_freq;
    endfunction

    function automatic int center_pulse(input int min_pulse, input int max_pulse);
        return min_pulse + (max_pulse - min_pulse) / 2;
    endfunction

    // Offset-binary coord scaled onto [min, min+span); floor by the right shift.
    function automatic int pulse_from_coord(
        input logic signed [COORD_EXT_W-1:0] coord,
        input int                            dw,
        input int                            min_pulse,
        input int                            span
    );
        longint off;
        off = longint'(coord) + (longint'(1) <<< (dw - 1));
        return min_pulse + int'((off * longint'(span)) >>> dw);
    endfunction

endpackage

// File: rtl/multi_axis_servo_driver_servo_channel.sv
// One servo channel: target capture, per-frame slew toward target, PWM compare, at_target flag.
module servo_channel
    import multi_axis_servo_driver_pkg::*;
#(
    parameter int DATA_WIDTH = 10,
    parameter int CNT_W      = 20,
    parameter int MIN_PULSE  = 25_000,
    parameter int SPAN       = 100_000,
    parameter int CENTER     = 75_000,
    parameter int STEP       = 2_500
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_capture,
    input  logic [DATA_WIDTH-1:0] i_coord,
    input  logic                  i_slew,
    input  logic [CNT_W-1:0]      i_cnt,
    output logic                  o_pwm,
    output logic                  o_at_target
);

    localparam logic [CNT_W-1:0]        CENTER_P = CNT_W'(CENTER);
    localparam logic signed [CNT_W:0]   STEP_P   = (CNT_W + 1)'(STEP);

    logic [CNT_W-1:0]          r_target;
    logic [CNT_W-1:0]          r_cur;
    logic                      r_pwm;
    logic                      r_at_target;
    logic signed [DATA_WIDTH-1:0] w_coord_s;
    logic signed [CNT_W:0]     w_diff;
    logic signed [CNT_W:0]     w_step;
    logic signed [CNT_W:0]     w_sum;

    assign w_coord_s = $signed(i_coord);
    assign w_diff    = $signed({1'b0, r_target}) - $signed({1'b0, r_cur});

    always_comb begin
        w_step = w_diff;
        if (w_diff > STEP_P) begin
            w_step = STEP_P;
        end else if (w_diff < -STEP_P) begin
            w_step = -STEP_P;
        end
    end

    assign w_sum = $signed({1'b0, r_cur}) + w_step;

    // cur only moves on the frame's last clock, so a pulse is never cut or stretched mid-frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_target    <= CENTER_P;
            r_cur       <= CENTER_P;
            r_pwm       <= 1'b0;
            r_at_target <= 1'b1;
        end else begin
            if (i_capture) begin
                r_target <= CNT_W'(pulse_from_coord(COORD_EXT_W'(w_coord_s), DATA_WIDTH,
                                                    MIN_PULSE, SPAN));
            end
            if (i_slew) begin
                r_cur <= w_sum[CNT_W-1:0];
            end
            r_pwm       <= i_en & (i_cnt < r_cur);
            r_at_target <= (r_cur == r_target);
        end
    end

    assign o_pwm       = r_pwm;
    assign o_at_target = r_at_target;

endmodule

// File: rtl/multi_axis_servo_driver.sv
// N-channel servo PWM driver: source mux and shared frame counter feeding per-channel slew/PWM.
module multi_axis_servo_driver
    import multi_axis_servo_driver_pkg::*;
#(
    parameter int N_CH       = 3,
    parameter int DATA_WIDTH = 10,
    parameter int CLK_FREQ   = 50_000_000,
    parameter int PWM_FREQ   = 50,
    parameter int MIN_PULSE  = 25_000,
    parameter int MAX_PULSE  = 125_000,
    parameter int MAX_STEP   = 2_500
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_en,
    input  logic                       i_sel_source,
    input  logic [N_CH*DATA_WIDTH-1:0] i_mem_coords,
    input  logic                       i_mem_valid,
    input  logic [N_CH*DATA_WIDTH-1:0] i_accel_coords,
    input  logic                       i_accel_valid,
    output logic [N_CH-1:0]            o_pwm_out,
    output logic                       o_frame_tick,
    output logic [N_CH-1:0]            o_at_target
);

    localparam int PERIOD = period_clocks(CLK_FREQ, PWM_FREQ);
    localparam int CNT_W  = $clog2(PERIOD + 1);
    localparam int SPAN   = MAX_PULSE - MIN_PULSE;
    localparam int CENTER = center_pulse(MIN_PULSE, MAX_PULSE);
    // A step larger than the frame is meaningless and would overflow the signed slew math.
    localparam int STEP_EFF = (MAX_STEP > PERIOD) ? PERIOD : MAX_STEP;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    if (!(MIN_PULSE < MAX_PULSE && MAX_PULSE < PERIOD && MAX_STEP >= 1)) begin : g_bad_params
        $error("multi_axis_servo_driver: need MIN_PULSE < MAX_PULSE < PERIOD and MAX_STEP >= 1");
    end

    logic [CNT_W-1:0]           r_cnt;
    logic                       w_last;
    logic                       w_slew;
    logic                       w_capture;
    logic [N_CH*DATA_WIDTH-1:0] w_coords;

    assign w_capture = i_sel_source ? i_accel_valid  : i_mem_valid;
    assign w_coords  = i_sel_source ? i_accel_coords : i_mem_coords;
    assign w_last    = (r_cnt == LAST);
    assign w_slew    = i_en & w_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (!i_en || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_frame_tick = w_slew;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        servo_channel #(
            .DATA_WIDTH (DATA_WIDTH),
            .CNT_W      (CNT_W),
            .MIN_PULSE  (MIN_PULSE),
            .SPAN       (SPAN),
            .CENTER     (CENTER),
            .STEP       (STEP_EFF)
        ) u_ch (
            .i_clk       (i_clk),
            .i_rst_n     (i_rst_n),
            .i_en        (i_en),
            .i_capture   (w_capture),
            .i_coord     (w_coords[gi*DATA_WIDTH +: DATA_WIDTH]),
            .i_slew      (w_slew),
            .i_cnt       (r_cnt),
            .o_pwm       (o_pwm_out[gi]),
            .o_at_target (o_at_target[gi])
        );
    end

endmodule

// File: tb/tb_multi_axis_servo_driver.sv
// Directed bench for multi_axis_servo_driver with a 100-clock frame and 10..30 clock pulses.
module tb_multi_axis_servo_driver;

    localparam int N_CH   = 3;
    localparam int DW     = 4;
    localparam int PERIOD = 100;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 en;
    logic                 sel;
    logic [N_CH*DW-1:0]   mem_c;
    logic                 mem_v;
    logic [N_CH*DW-1:0]   acc_c;
    logic                 acc_v;
    logic [N_CH-1:0]      pwm;
    logic                 tick;
    logic [N_CH-1:0]      at;

    int n_cmp = 0;
    int n_mis = 0;
    int hw[N_CH];
    int ticks;
    int tick_last;

    always #5 clk = ~clk;

    multi_axis_servo_driver #(
        .N_CH       (N_CH),
        .DATA_WIDTH (DW),
        .CLK_FREQ   (1000),
        .PWM_FREQ   (10),
        .MIN_PULSE  (10),
        .MAX_PULSE  (30),
        .MAX_STEP   (4)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_en           (en),
        .i_sel_source   (sel),
        .i_mem_coords   (mem_c),
        .i_mem_valid    (mem_v),
        .i_accel_coords (acc_c),
        .i_accel_valid  (acc_v),
        .o_pwm_out      (pwm),
        .o_frame_tick   (tick),
        .o_at_target    (at)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [N_CH*DW-1:0] pack3(input int c0, input int c1, input int c2);
        return {DW'(c2), DW'(c1), DW'(c0)};
    endfunction

    // Samples one full frame starting right after a frame_tick sample; any strobe is one cycle.
    task automatic measure_frame();
        ticks = 0;
        for (int c = 0; c < N_CH; c++) hw[c] = 0;
        for (int k = 0; k < PERIOD; k++) begin
            @(negedge clk);
            mem_v = 1'b0;
            acc_v = 1'b0;
            for (int c = 0; c < N_CH; c++) if (pwm[c]) hw[c]++;
            if (tick) ticks++;
        end
        tick_last = int'(tick);
    endtask

    task automatic check_frame(input string tag, input int e0, input int e1, input int e2,
                               input int eat);
        measure_frame();
        $display("%s: widths %0d %0d %0d, ticks %0d, at_target %0d", tag, hw[0], hw[1], hw[2],
                 ticks, at);
        chk({tag, ".w0"}, hw[0], e0);
        chk({tag, ".w1"}, hw[1], e1);
        chk({tag, ".w2"}, hw[2], e2);
        chk({tag, ".ticks"}, ticks, 1);
        chk({tag, ".tick_last"}, tick_last, 1);
        chk({tag, ".at_target"}, int'(at), eat);
    endtask

    // exp_n < 0 means the distance to the tick is not checked, only that it arrives.
    task automatic wait_tick(input string tag, input int exp_n);
        int n;
        int found;
        n = 0;
        found = 0;
        for (int k = 0; k < 3 * PERIOD; k++) begin
            @(negedge clk);
            n++;
            if (tick) begin
                found = 1;
                break;
            end
        end
        $display("%s: frame_tick after %0d clocks", tag, n);
        chk({tag, ".found"}, found, 1);
        if (exp_n >= 0) chk({tag, ".dist"}, n, exp_n);
    endtask

    task automatic strobe_mid(input bit to_mem, input bit to_acc);
        repeat (10) @(negedge clk);
        mem_v = to_mem;
        acc_v = to_acc;
        @(negedge clk);
        mem_v = 1'b0;
        acc_v = 1'b0;
    endtask

    initial begin
        int highs;
        int tcount;
        int wp[N_CH];

        rst_n = 1'b0;
        en    = 1'b1;
        sel   = 1'b0;
        mem_c = '0;
        mem_v = 1'b0;
        acc_c = '0;
        acc_v = 1'b0;

        repeat (2) @(negedge clk);
        $display("reset: pwm %0d tick %0d at_target %0d", pwm, tick, at);
        chk("reset.pwm", int'(pwm), 0);
        chk("reset.tick", int'(tick), 0);
        chk("reset.at_target", int'(at), 7);
        rst_n = 1'b1;
        wait_tick("rst_release", PERIOD - 1);
        check_frame("idle", 20, 20, 20, 7);

        // ch0 +7 -> target 28, slewing 4 per frame
        mem_c = pack3(7, 0, 0);
        strobe_mid(1'b1, 1'b0);
        wait_tick("mem_strobe", -1);
        check_frame("mem1", 24, 20, 20, 6);
        check_frame("mem2", 28, 20, 20, 7);
        check_frame("mem3", 28, 20, 20, 7);

        // Unselected source strobe must be ignored
        acc_c = pack3(7, -8, 0);
        strobe_mid(1'b0, 1'b1);
        wait_tick("acc_ignored", -1);
        check_frame("acc_ign", 28, 20, 20, 7);

        sel = 1'b1;
        strobe_mid(1'b0, 1'b1);
        wait_tick("acc_strobe", -1);
        check_frame("acc1", 28, 16, 20, 5);
        check_frame("acc2", 28, 12, 20, 5);
        check_frame("acc3", 28, 10, 20, 7);

        // Strobe on the tick clock: that boundary still slews toward the old target
        acc_c = pack3(7, -8, 7);
        acc_v = 1'b1;
        check_frame("tickcap1", 28, 10, 20, 3);
        check_frame("tickcap2", 28, 10, 24, 3);
        check_frame("tickcap3", 28, 10, 28, 7);

        // en low for 37 clocks mid-pulse
        repeat (10) @(negedge clk);
        chk("en_pre.pwm", int'(pwm), 7);
        en = 1'b0;
        highs = 0;
        tcount = 0;
        for (int k = 0; k < 37; k++) begin
            @(negedge clk);
            if (pwm != '0) highs++;
            if (tick) tcount++;
        end
        $display("en_off: pwm-high samples %0d, ticks %0d", highs, tcount);
        chk("en_off.pwm", highs, 0);
        chk("en_off.ticks", tcount, 0);
        en = 1'b1;
        tcount = 0;
        for (int c = 0; c < N_CH; c++) wp[c] = 0;
        for (int k = 0; k < PERIOD - 1; k++) begin
            @(negedge clk);
            if (k == 0) chk("en_on.first_pwm", int'(pwm), 7);
            for (int c = 0; c < N_CH; c++) if (pwm[c]) wp[c]++;
            if (tick) tcount++;
        end
        $display("en_on: widths %0d %0d %0d, ticks %0d, tick_last %0d", wp[0], wp[1], wp[2],
                 tcount, tick);
        chk("en_on.w0", wp[0], 28);
        chk("en_on.w1", wp[1], 10);
        chk("en_on.w2", wp[2], 28);
        chk("en_on.ticks", tcount, 1);
        chk("en_on.tick_last", int'(tick), 1);
        check_frame("en_post", 28, 10, 28, 7);

        // Async reset in the middle of a pulse
        repeat (5) @(negedge clk);
        chk("rst_pre.pwm", int'(pwm), 7);
        #2 rst_n = 1'b0;
        #1;
        $display("rst_async: pwm %0d tick %0d at_target %0d", pwm, tick, at);
        chk("rst_async.pwm", int'(pwm), 0);
        chk("rst_async.tick", int'(tick), 0);
        chk("rst_async.at_target", int'(at), 7);
        @(negedge clk);
        rst_n = 1'b1;
        wait_tick("rst2_release", PERIOD - 1);
        check_frame("rst_post", 20, 20, 20, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
